// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, helper functions and types for the SDF FFT pipeline
package fft_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  // Smallest r with 2**r >= n; used to size counters from the point count.
  function automatic int fft_log2(input int n);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < n) r = b + 1;
    end
    return r;
  endfunction

  // Reverse the low log_n bits of k; bits above log_n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int log_n);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < log_n) r[b] = k[log_n - 1 - b];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// rtl/reorder_ram.sv - simple dual-port bank RAM, one write port and one registered read port
module reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1 << AW) - 1];

  // Write when enabled; read every cycle into the output register (contents never reset)
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bitrev_reorder.sv
// rtl/bitrev_reorder.sv - ping-pong bit-reversed to natural order reorder buffer (option: REORDER_OREG_EN)
module bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 64,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i
);

  localparam int LOG_N = fft_log2(N);

  logic [LOG_N-1:0]   wcount;
  logic [LOG_N-1:0]   rcount;
  logic [LOG_N-1:0]   wr_rev;
  logic               wbank;
  logic               rbank;
  logic               bank_ready;
  logic               rd_valid;
  rstate_t            rstate;
  logic [LOG_N:0]     wr_addr;
  logic [LOG_N:0]     rd_addr;
  logic [2*WIDTH-1:0] rd_data;
  logic [WIDTH-1:0]   mux_r;
  logic [WIDTH-1:0]   mux_i;

  assign wr_rev  = LOG_N'(bitrev(32'(wcount), LOG_N));
  assign wr_addr = {wbank, wr_rev};
  assign rd_addr = {rbank, rcount};

  reorder_ram #(
    .AW (LOG_N + 1),
    .DW (2 * WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (idata_en),
    .wr_addr (wr_addr),
    .wr_data ({idata_r, idata_i}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Write side: count samples, swap banks on a complete frame, drop partial frames
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcount     <= '0;
      wbank      <= 1'b0;
      bank_ready <= 1'b0;
    end else begin
      bank_ready <= 1'b0;
      if (idata_en) begin
        wcount <= wcount + 1'b1;
        if (&wcount) begin
          wbank      <= ~wbank;
          bank_ready <= 1'b1;
        end
      end else begin
        wcount <= '0;
      end
    end
  end

  // Read FSM: drain a full bank in natural order, chaining straight into the next one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rstate   <= R_IDLE;
      rcount   <= '0;
      rbank    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      // Tracks the RAM read register: data for this cycle's address appears next cycle
      rd_valid <= (rstate == R_DRAIN);
      case (rstate)
        R_IDLE: begin
          if (bank_ready) begin
            rbank  <= ~wbank;
            rcount <= '0;
            rstate <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          rcount <= rcount + 1'b1;
          if (&rcount) begin
            if (bank_ready) rbank  <= ~wbank;
            else            rstate <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign mux_r = rd_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
  assign mux_i = rd_valid ? rd_data[WIDTH-1:0]       : '0;

`ifdef REORDER_OREG_EN
  // Extra output stage for timing closure; adds one cycle of latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      odata_en <= 1'b0;
      odata_r  <= '0;
      odata_i  <= '0;
    end else begin
      odata_en <= rd_valid;
      odata_r  <= mux_r;
      odata_i  <= mux_i;
    end
  end
`else
  assign odata_en = rd_valid;
  assign odata_r  = mux_r;
  assign odata_i  = mux_i;
`endif

endmodule

// File: tb/tb_bitrev_reorder.sv
// tb/tb_bitrev_reorder.sv - self-checking bench for bitrev_reorder (N=64 and N=4 instances)
module tb_bitrev_reorder;

  localparam int N     = 64;
  localparam int LOG_N = 6;
  localparam int W     = 16;
`ifdef REORDER_OREG_EN
  localparam int LAT   = N + 2;
  localparam int LAT4  = 6;
`else
  localparam int LAT   = N + 1;
  localparam int LAT4  = 5;
`endif

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         idata_en;
  logic [W-1:0] idata_r;
  logic [W-1:0] idata_i;
  logic         odata_en;
  logic [W-1:0] odata_r;
  logic [W-1:0] odata_i;
  logic         en4;
  logic [W-1:0] ir4;
  logic [W-1:0] ii4;
  logic         oen4;
  logic [W-1:0] or4;
  logic [W-1:0] oi4;

  int cyc     = 0;
  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] i;
    int           cyc;
  } exp_t;

  typedef struct {
    int frames;
    int off0;
    int step;
    int abort_len;
  } scen_t;

  exp_t  sbq[$];
  exp_t  mon_e;
  scen_t tbl[3];

  bitrev_reorder #(.N(N), .WIDTH(W)) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .idata_en (idata_en),
    .idata_r  (idata_r),
    .idata_i  (idata_i),
    .odata_en (odata_en),
    .odata_r  (odata_r),
    .odata_i  (odata_i)
  );

  bitrev_reorder #(.N(4), .WIDTH(W)) u_dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .idata_en (en4),
    .idata_r  (ir4),
    .idata_i  (ii4),
    .odata_en (oen4),
    .odata_r  (or4),
    .odata_i  (oi4)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int tb_rev(input int k, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) begin
      if ((k & (1 << b)) != 0) r = r | (1 << (bits - 1 - b));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (odata_en === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output_en", 32'(odata_en), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_r", 32'(odata_r), 32'(mon_e.r));
        chk("out_i", 32'(odata_i), 32'(mon_e.i));
        chk("out_cycle", cyc, mon_e.cyc);
      end
    end else begin
      chk("idle_r_zero", 32'(odata_r), 32'd0);
      chk("idle_i_zero", 32'(odata_i), 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      idata_en = 1'b0;
      idata_r  = '0;
      idata_i  = '0;
    end
  endtask

  task automatic drive_frame(input int off, input int nsamp, input bit push, input int rst_k);
    int           t0;
    logic [W-1:0] v;
    exp_t         ex;
    for (int k = 0; k < nsamp; k++) begin
      @(negedge clock);
      v        = W'(off + tb_rev(k, LOG_N));
      idata_en = 1'b1;
      idata_r  = v;
      idata_i  = -v;
      if (k == 0) begin
        t0 = cyc + 1;
        if (push) begin
          for (int m = 0; m < N; m++) begin
            ex.r   = W'(off + m);
            ex.i   = W'(-(off + m));
            ex.cyc = t0 + LAT + m;
            sbq.push_back(ex);
          end
        end
      end
      if (k == rst_k) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_pulse_en", 32'(odata_en), 32'd0);
        chk("reset_pulse_r", 32'(odata_r), 32'd0);
        chk("reset_pulse_i", 32'(odata_i), 32'd0);
        sbq.delete();
      end
      if (rst_k >= 0 && k == rst_k + 2) reset_n = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 4 * N && sbq.size() != 0; c++) @(negedge clock);
    chk(name, sbq.size(), 0);
    repeat (N) @(negedge clock);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1);
  end

  initial begin
    int           t4;
    logic [W-1:0] a4[4];
    logic [W-1:0] e4[4];

    idata_en = 1'b0;
    idata_r  = '0;
    idata_i  = '0;
    en4      = 1'b0;
    ir4      = '0;
    ii4      = '0;

    tbl[0] = '{1, 0, 0, 0};
    tbl[1] = '{3, 0, 100, 0};
    tbl[2] = '{1, 500, 0, 10};

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_en",    32'(odata_en), 32'd0);
    chk("reset_r",     32'(odata_r),  32'd0);
    chk("reset_i",     32'(odata_i),  32'd0);
    chk("reset_en_n4", 32'(oen4),     32'd0);
    chk("reset_r_n4",  32'(or4),      32'd0);
    chk("reset_i_n4",  32'(oi4),      32'd0);
    reset_n = 1'b1;
    idle(2);

    for (int s = 0; s < 3; s++) begin
      if (tbl[s].abort_len > 0) begin
        drive_frame(0, tbl[s].abort_len, 1'b0, -1);
        idle(5);
      end
      for (int f = 0; f < tbl[s].frames; f++)
        drive_frame(tbl[s].off0 + f * tbl[s].step, N, 1'b1, -1);
      idle(1);
      drain($sformatf("scen%0d_drained", s));
    end

    drive_frame(0, N, 1'b1, -1);
    drive_frame(1000, N, 1'b1, LAT - N + 21);
    idle(3 * N);
    chk("post_reset_silent", sbq.size(), 0);
    drive_frame(300, N, 1'b1, -1);
    idle(1);
    drain("after_reset_frame");

    a4[0] = 16'd11; a4[1] = 16'd22; a4[2] = 16'd33; a4[3] = 16'd44;
    e4[0] = 16'd11; e4[1] = 16'd33; e4[2] = 16'd22; e4[3] = 16'd44;
    t4 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      en4 = 1'b1;
      ir4 = a4[k];
      ii4 = -a4[k];
      if (k == 0) t4 = cyc + 1;
    end
    @(negedge clock);
    en4 = 1'b0;
    ir4 = '0;
    ii4 = '0;
    for (int c = 0; c < 12; c++) begin
      if (cyc >= t4 + LAT4 && cyc < t4 + LAT4 + 4) begin
        chk("n4_en", 32'(oen4), 32'd1);
        chk("n4_r",  32'(or4),  32'(e4[cyc - t4 - LAT4]));
        chk("n4_i",  32'(oi4),  32'(W'(-e4[cyc - t4 - LAT4])));
      end else begin
        chk("n4_idle_en", 32'(oen4), 32'd0);
      end
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
